core_ma_lsu_split_access: RTL

Parametrised load/store access engine between the MA stage and the Avalon-MM data master. Each accepted core request is split into one or two bus-width-aligned Avalon transactions when the access straddles a bus-word boundary. Write data and byte enables are shifted per beat. For reads, the returned beats are collected, merged, then sign- or zero-extended before a single response goes back to the core. Unlike the previous generator, it handles read-data reassembly, request/response handshakes and errors, and works for 32- or 64-bit buses.

---
 rtl/core_ma_lsu_split_access.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/core_ma_lsu_split_access.sv
// MA-stage load/store engine: splits each core access into one or two bus-aligned
// Avalon-MM beats, reassembles and extends read data, returns one response per request.
//  state | meaning
//  IDLE  | ready for a core request
//  SEND  | presenting beat[sent_cnt] on the Avalon command channel
//  WAIT  | all commands accepted, collecting outstanding read beats
//  RESP  | one-cycle registered response to the core
module core_ma_lsu_split_access #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rest,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [ADDR_W-1:0]       i_req_addr,
    input  logic [8*DATA_BYTES-1:0] i_req_wdata,
    input  logic                    i_req_read,
    input  logic                    i_req_write,
    input  logic [3:0]              i_req_len,
    input  logic                    i_req_unsigned,
    output logic                    o_resp_valid,
    output logic [8*DATA_BYTES-1:0] o_resp_rdata,
    output logic                    o_resp_err,
    output logic [ADDR_W-1:0]       o_avl_m0_address,
    output logic                    o_avl_m0_read,
    output logic                    o_avl_m0_write,
    output logic [DATA_BYTES-1:0]   o_avl_m0_byte_en,
    output logic [8*DATA_BYTES-1:0] o_avl_m0_write_data,
    input  logic                    i_avl_m0_request_ready,
    input  logic [8*DATA_BYTES-1:0] i_avl_m0_read_data,
    input  logic                    i_avl_m0_read_data_valid
);
    localparam int DW  = 8*DATA_BYTES;
    localparam int OFF = $clog2(DATA_BYTES);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;
    localparam logic [2*DATA_BYTES-1:0] ONE2 = 1;
    localparam logic [ADDR_W-1:0]       STEP = ADDR_W'(DATA_BYTES);

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DW-1:0]       r_wdata;
    logic [3:0]          r_len;
    logic                r_read;
    logic                r_unsigned;
    logic                r_two;
    logic                r_sent_cnt;
    logic [1:0]          r_rcv_cnt;
    logic [DW-1:0]       r_buf0;
    logic [DW-1:0]       r_buf1;
    logic                r_resp_valid;
    logic                r_resp_err;
    logic [DW-1:0]       r_resp_rdata;

    logic                w_hs;
    logic                w_legal;
    logic                w_split_in;
    logic [OFF-1:0]      w_off;
    logic [2*DATA_BYTES-1:0] w_mask2;
    logic [2*DATA_BYTES-1:0] w_be2;
    logic [2*DW-1:0]     w_wd2;
    logic [ADDR_W-1:0]   w_a0;
    logic [ADDR_W-1:0]   w_a1;
    logic                w_beat_in;
    logic [DW-1:0]       w_buf0_n;
    logic [DW-1:0]       w_buf1_n;
    logic [1:0]          w_rcv_n;
    logic [1:0]          w_nbeats;
    logic [DW-1:0]       w_raw;
    logic                w_sign;
    logic [DW-1:0]       w_ext;
    logic [1:0]          w_state_n;

    assign w_hs       = i_req_valid && (r_state == S_IDLE);
    assign w_legal    = ((i_req_len == 4'd1) || (i_req_len == 4'd2) || (i_req_len == 4'd4) ||
                         (i_req_len == 4'd8)) && (int'(i_req_len) <= DATA_BYTES) &&
                        (i_req_read ^ i_req_write);
    assign w_split_in = (int'(i_req_addr[OFF-1:0]) + int'(i_req_len)) > DATA_BYTES;

    // Both beats come from one double-width shift: low half is beat0, high half is beat1.
    assign w_off   = r_addr[OFF-1:0];
    assign w_mask2 = (ONE2 << r_len) - ONE2;
    assign w_be2   = w_mask2 << w_off;
    assign w_wd2   = {{DW{1'b0}}, r_wdata} << {w_off, 3'b000};
    assign w_a0    = {r_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
    assign w_a1    = w_a0 + STEP;

    assign o_avl_m0_address    = r_sent_cnt ? w_a1 : w_a0;
    assign o_avl_m0_byte_en    = r_sent_cnt ? w_be2[2*DATA_BYTES-1:DATA_BYTES] : w_be2[DATA_BYTES-1:0];
    assign o_avl_m0_write_data = r_sent_cnt ? w_wd2[2*DW-1:DW] : w_wd2[DW-1:0];
    assign o_avl_m0_read       = (r_state == S_SEND) && r_read;
    assign o_avl_m0_write      = (r_state == S_SEND) && !r_read;
    assign o_req_ready         = (r_state == S_IDLE);
    assign o_resp_valid        = r_resp_valid;
    assign o_resp_rdata        = r_resp_rdata;
    assign o_resp_err          = r_resp_err;

    assign w_beat_in = ((r_state == S_SEND) || (r_state == S_WAIT)) &&
                       i_avl_m0_read_data_valid && (r_rcv_cnt != 2'd2);
    assign w_buf0_n  = (w_beat_in && (r_rcv_cnt == 2'd0)) ? i_avl_m0_read_data : r_buf0;
    assign w_buf1_n  = (w_beat_in && (r_rcv_cnt == 2'd1)) ? i_avl_m0_read_data : r_buf1;
    assign w_rcv_n   = r_rcv_cnt + {1'b0, w_beat_in};
    assign w_nbeats  = r_two ? 2'd2 : 2'd1;

    // Merge uses the next-buffer values so the final beat can complete in the same cycle.
    assign w_raw = DW'({(r_two ? w_buf1_n : {DW{1'b0}}), w_buf0_n} >> {w_off, 3'b000});

    always_comb begin
        w_sign = 1'b0;
        case (r_len)
            4'd1:    w_sign = w_raw[7];
            4'd2:    w_sign = w_raw[15];
            4'd4:    w_sign = w_raw[31];
            default: w_sign = w_raw[DW-1];
        endcase
        w_sign = w_sign & ~r_unsigned;
        w_ext  = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_ext[8*i +: 8] = (i < int'(r_len)) ? w_raw[8*i +: 8] : {8{w_sign}};
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: if (w_hs) w_state_n = w_legal ? S_SEND : S_RESP;
            S_SEND: begin
                if (i_avl_m0_request_ready && (r_sent_cnt == r_two)) begin
                    if (!r_read || (w_rcv_n == w_nbeats)) w_state_n = S_RESP;
                    else                                  w_state_n = S_WAIT;
                end
            end
            S_WAIT:  if (w_rcv_n == w_nbeats) w_state_n = S_RESP;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rest) begin
        if (!i_rest) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_len        <= '0;
            r_read       <= 1'b0;
            r_unsigned   <= 1'b0;
            r_two        <= 1'b0;
            r_sent_cnt   <= 1'b0;
            r_rcv_cnt    <= '0;
            r_buf0       <= '0;
            r_buf1       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_n;
            r_buf0       <= w_buf0_n;
            r_buf1       <= w_buf1_n;
            r_resp_valid <= (w_state_n == S_RESP);
            case (r_state)
                S_IDLE: begin
                    r_sent_cnt <= 1'b0;
                    r_rcv_cnt  <= '0;
                    if (w_hs) begin
                        r_addr       <= i_req_addr;
                        r_wdata      <= i_req_wdata;
                        r_len        <= i_req_len;
                        r_read       <= i_req_read;
                        r_unsigned   <= i_req_unsigned;
                        r_two        <= w_split_in;
                        r_resp_err   <= !w_legal;
                        r_resp_rdata <= '0;
                    end
                end
                S_SEND: begin
                    r_rcv_cnt <= w_rcv_n;
                    if (i_avl_m0_request_ready) r_sent_cnt <= 1'b1;
                end
                S_WAIT:  r_rcv_cnt <= w_rcv_n;
                default: ;
            endcase
            if ((r_state != S_IDLE) && (w_state_n == S_RESP))
                r_resp_rdata <= r_read ? w_ext : '0;
        end
    end
endmodule
